// File: rtl/multi_port_slow_memory.sv
// Shared cache-line store for NUM_PORTS requesters: round-robin arbitration, one
// access in flight, fixed LATENCY from grant to ready, single-ported line array.
module multi_port_slow_memory #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_W     = 28,
  parameter int LINE_W     = 128,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4,
  localparam int GID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        mem_read,
  input  logic [NUM_PORTS-1:0]        mem_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] mem_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] mem_wdata,
  output logic [NUM_PORTS*LINE_W-1:0] mem_rdata,
  output logic [NUM_PORTS-1:0]        mem_ready,
  output logic [GID_W-1:0]            grant_id,
  output logic                        busy,
  output logic                        protocol_err
);

  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

  state_t                state_reg;
  logic [7:0]            cnt_reg;
  logic [GID_W-1:0]      grant_reg;
  logic [GID_W-1:0]      rr_ptr_reg;
  logic                  write_reg;
  logic                  busy_reg;
  logic                  err_reg;
  logic [DEPTH_LOG2-1:0] idx_reg;
  logic [LINE_W-1:0]     wdata_reg;
  logic [NUM_PORTS-1:0]  ready_reg;

  logic [LINE_W-1:0]     mem [0:2**DEPTH_LOG2-1];
  logic [LINE_W-1:0]     rdata_reg [NUM_PORTS];

  logic [DEPTH_LOG2-1:0] idx_lane [NUM_PORTS];
  logic [LINE_W-1:0]     wdata_lane [NUM_PORTS];
  logic [NUM_PORTS-1:0]  req;
  logic [GID_W-1:0]      sel;
  logic [GID_W-1:0]      cand;
  logic                  any_req;
  logic                  rd_en;
  logic [GID_W-1:0]      rd_port;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  unused_addr_bits;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_lane
      assign idx_lane[gi]                    = mem_addr[gi*ADDR_W +: DEPTH_LOG2];
      assign wdata_lane[gi]                  = mem_wdata[gi*LINE_W +: LINE_W];
      assign mem_rdata[gi*LINE_W +: LINE_W]  = rdata_reg[gi];
    end
  endgenerate

  // Upper line-address bits alias onto the array and carry no meaning here.
  assign unused_addr_bits = ^mem_addr;

  assign req = mem_read | mem_write;

  // Search upward from rr_ptr with wrap; descending loop leaves the nearest hit.
  always_comb begin
    sel     = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = GID_W'((int'(rr_ptr_reg) + k) % NUM_PORTS);
      if (req[cand]) begin
        sel     = cand;
        any_req = 1'b1;
      end
    end
  end

  // Read data is registered so it is valid during the ready cycle; with LATENCY=1
  // that means reading straight from the granting request.
  always_comb begin
    rd_en   = 1'b0;
    rd_port = grant_reg;
    rd_idx  = idx_reg;
    if (state_reg == IDLE) begin
      rd_port = sel;
      rd_idx  = idx_lane[sel];
      rd_en   = any_req && !mem_write[sel] && (LATENCY == 1);
    end else if (state_reg == BUSY) begin
      rd_en   = !write_reg && (cnt_reg == 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) rdata_reg[p] <= '0;
    end else if (rd_en) begin
      rdata_reg[rd_port] <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_reg == BUSY && cnt_reg == 8'd0 && write_reg)
      mem[idx_reg] <= wdata_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      write_reg  <= 1'b0;
      idx_reg    <= '0;
      wdata_reg  <= '0;
      ready_reg  <= '0;
      busy_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      ready_reg <= '0;
      if (|(mem_read & mem_write)) err_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg <= BUSY;
            busy_reg  <= 1'b1;
            grant_reg <= sel;
            write_reg <= mem_write[sel];
            idx_reg   <= idx_lane[sel];
            wdata_reg <= wdata_lane[sel];
            cnt_reg   <= 8'(LATENCY - 1);
            if (LATENCY == 1) ready_reg[sel] <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_reg == 8'd0) begin
            state_reg <= TURN;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
            if (cnt_reg == 8'd1) ready_reg[grant_reg] <= 1'b1;
          end
        end
        TURN: begin
          rr_ptr_reg <= GID_W'((int'(grant_reg) + 1) % NUM_PORTS);
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_ready    = ready_reg;
  assign grant_id     = grant_reg;
  assign busy         = busy_reg;
  assign protocol_err = err_reg;

endmodule

// File: tb/tb_multi_port_slow_memory.sv
// Scoreboard bench for multi_port_slow_memory: expected ready cycle and read data
// are queued at issue and matched against each mem_ready pulse.
module tb_multi_port_slow_memory;
  localparam int NUM_PORTS  = 2;
  localparam int ADDR_W     = 28;
  localparam int LINE_W     = 128;
  localparam int DEPTH_LOG2 = 10;
  localparam int LATENCY    = 4;
  localparam int GID_W      = 1;
  localparam int SLOT       = LATENCY + 2;

  typedef logic [LINE_W-1:0] line_t;
  typedef struct {
    int    port;
    bit    is_read;
    line_t data;
    int    due;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_PORTS-1:0]        mem_read;
  logic [NUM_PORTS-1:0]        mem_write;
  logic [NUM_PORTS*ADDR_W-1:0] mem_addr;
  logic [NUM_PORTS*LINE_W-1:0] mem_wdata;
  logic [NUM_PORTS*LINE_W-1:0] mem_rdata;
  logic [NUM_PORTS-1:0]        mem_ready;
  logic [GID_W-1:0]            grant_id;
  logic                        busy;
  logic                        protocol_err;

  multi_port_slow_memory #(
    .NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W), .LINE_W(LINE_W),
    .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .grant_id(grant_id), .busy(busy),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  localparam line_t D_A5 = {16{8'hA5}};
  localparam line_t D_9  = 128'h1234_0000_0000_0000_0000_0000_0000_5678;
  localparam line_t D_FF = {LINE_W{1'b1}};
  localparam line_t D_AL = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_0400;
  localparam line_t D_7  = 128'h0707_0707_CAFE_F00D_0707_0707_BEEF_0007;

  task automatic check_val(input string tag, input line_t got, input line_t exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input int p, input bit rd, input bit wr,
                       input logic [ADDR_W-1:0] a, input line_t d,
                       input line_t exp_data, input int lat);
    mem_read[p]  = rd;
    mem_write[p] = wr;
    mem_addr[p*ADDR_W +: ADDR_W]  = a;
    mem_wdata[p*LINE_W +: LINE_W] = d;
    sb.push_back('{port: p, is_read: (rd && !wr), data: exp_data, due: cyc + lat});
    $display("[TB] issue port=%0d rd=%0b wr=%0b addr=%h due=%0d", p, rd, wr, a, cyc + lat);
  endtask

  // Serve all queued requests; optionally re-issue reads to keep ports contending.
  task automatic run(input int reissue, input bit check_rr, input int first_grant);
    int    served;
    int    budget;
    int    k;
    exp_t  e;
    served = 0;
    budget = 0;
    @(negedge clk);
    check_val("busy_after_grant", line_t'(busy), line_t'(1));
    check_val("grant_id", line_t'(grant_id), line_t'(first_grant));
    while (sb.size() != 0 && budget < 200) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (mem_ready[p]) begin
          k = -1;
          foreach (sb[i]) if (k < 0 && sb[i].port == p) k = i;
          check_val("ready_expected", line_t'(k >= 0), line_t'(1));
          if (k >= 0) begin
            e = sb[k];
            $display("[TB] ready port=%0d cyc=%0d rdata=%h", p, cyc,
                     mem_rdata[p*LINE_W +: LINE_W]);
            check_val($sformatf("ready_cycle_p%0d", p), line_t'(cyc), line_t'(e.due));
            if (e.is_read)
              check_val($sformatf("rdata_p%0d", p), mem_rdata[p*LINE_W +: LINE_W], e.data);
            if (check_rr)
              check_val("rr_order", line_t'(p), line_t'(served % NUM_PORTS));
            served++;
            sb.delete(k);
            if (reissue > 0 && e.is_read) begin
              reissue--;
              sb.push_back('{port: p, is_read: 1'b1, data: e.data, due: cyc + NUM_PORTS*SLOT});
            end else begin
              mem_read[p]  = 1'b0;
              mem_write[p] = 1'b0;
            end
          end
        end
      end
      if (sb.size() != 0) begin
        @(negedge clk);
        budget++;
      end
    end
    check_val("sb_drained", line_t'(sb.size()), line_t'(0));
    sb.delete();
    mem_read  = '0;
    mem_write = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [NUM_PORTS-1:0] saw_ready;
    rst       = 1'b1;
    mem_read  = '0;
    mem_write = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", line_t'(mem_ready), line_t'(0));
    check_val("rst_busy", line_t'(busy), line_t'(0));
    check_val("rst_grant", line_t'(grant_id), line_t'(0));
    check_val("rst_perr", line_t'(protocol_err), line_t'(0));
    for (int p = 0; p < NUM_PORTS; p++)
      check_val($sformatf("rst_rdata_p%0d", p), mem_rdata[p*LINE_W +: LINE_W], '0);
    rst = 1'b0;
    @(negedge clk);

    // Preload lines 5 and 3 through the ports, then reset the arbiter.
    start(1, 1'b0, 1'b1, 28'd5, D_A5, '0, LATENCY);  run(0, 1'b0, 1);
    start(0, 1'b0, 1'b1, 28'd3, D_FF, '0, LATENCY);  run(0, 1'b0, 0);
    pulse_rst();

    // Single read; the other lane must stay at its reset value.
    start(0, 1'b1, 1'b0, 28'd5, '0, D_A5, LATENCY);  run(0, 1'b0, 0);
    check_val("lane1_untouched", mem_rdata[LINE_W +: LINE_W], '0);

    // Write then read back from another port.
    start(1, 1'b0, 1'b1, 28'd9, D_9, '0, LATENCY);   run(0, 1'b0, 1);
    start(0, 1'b1, 1'b0, 28'd9, '0, D_9, LATENCY);   run(0, 1'b0, 0);

    // Contention from reset, then continuous requests alternating 0,1,0,1.
    pulse_rst();
    start(0, 1'b1, 1'b0, 28'd5, '0, D_A5, LATENCY);
    start(1, 1'b1, 1'b0, 28'd9, '0, D_9, LATENCY + SLOT);
    run(2, 1'b1, 0);

    // Aliasing: 0x400 and 0x000 share line 0.
    start(0, 1'b0, 1'b1, 28'h400, D_AL, '0, LATENCY); run(0, 1'b0, 0);
    start(1, 1'b1, 1'b0, 28'h000, '0, D_AL, LATENCY); run(0, 1'b0, 1);
    check_val("perr_still_clear", line_t'(protocol_err), line_t'(0));

    // Reset during BUSY cycle 2 of a write to line 3 aborts it.
    mem_write[0] = 1'b1;
    mem_addr[0 +: ADDR_W]  = 28'd3;
    mem_wdata[0 +: LINE_W] = '0;
    @(negedge clk);
    check_val("abort_busy_cycle1", line_t'(busy), line_t'(1));
    @(negedge clk);
    rst       = 1'b1;
    mem_write = '0;
    @(negedge clk);
    $display("[TB] abort reset applied busy=%0b ready=%b", busy, mem_ready);
    check_val("abort_busy_cleared", line_t'(busy), line_t'(0));
    check_val("abort_no_ready", line_t'(mem_ready), line_t'(0));
    rst = 1'b0;
    saw_ready = '0;
    repeat (6) begin
      @(negedge clk);
      saw_ready |= mem_ready;
    end
    check_val("abort_no_late_ready", line_t'(saw_ready), line_t'(0));
    start(1, 1'b1, 1'b0, 28'd3, '0, D_FF, LATENCY);  run(0, 1'b0, 1);

    // Read and write together: treated as a write, protocol_err sticky until reset.
    start(0, 1'b1, 1'b1, 28'd7, D_7, '0, LATENCY);   run(0, 1'b0, 0);
    check_val("perr_set", line_t'(protocol_err), line_t'(1));
    start(1, 1'b1, 1'b0, 28'd7, '0, D_7, LATENCY);   run(0, 1'b0, 1);
    check_val("perr_sticky", line_t'(protocol_err), line_t'(1));
    pulse_rst();
    check_val("perr_cleared_by_rst", line_t'(protocol_err), line_t'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_port_slow_memory.md
# multi_port_slow_memory

Parametrised successor to the two single-port `slow_memory` instances (one for instructions, one for data) in the CHIP-level bench. It serves `NUM_PORTS` cache-line requesters from one shared line array, with configurable access latency and round-robin arbitration. The caches' `mem_read`/`mem_write`/`mem_ready` handshake is unchanged, so `I_cache` and `D_cache` can share one backing store, as in a unified-memory system.

## Interface
- `NUM_PORTS`, 2: number of requester channels, 1..8
- `ADDR_W`, 28: line-address width (byte address bits 31:4)
- `LINE_W`, 128: line width in bits
- `DEPTH_LOG2`, 10: log2 of array depth in lines
- `LATENCY`, 4: cycles from grant to `mem_ready`, 1..255

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `mem_read`  in  NUM_PORTS  per-port read request; held until that port's ready
- `mem_write`  in  NUM_PORTS  per-port write request; held until that port's ready
- `mem_addr`  in  NUM_PORTS*ADDR_W  packed line addresses; port p occupies bits [p*ADDR_W +: ADDR_W]
- `mem_wdata`  in  NUM_PORTS*LINE_W  packed write lines
- `mem_rdata`  out  NUM_PORTS*LINE_W  packed read lines; port p holds its last read line
- `mem_ready`  out  NUM_PORTS  one-cycle completion pulse per port
- `grant_id`  out  log2(NUM_PORTS), min 1  port currently being served; valid when `busy`=1
- `busy`  out  1  an access is in flight
- `protocol_err`  out  1  sticky: a port asserted read and write in the same cycle

## Operation
- Storage: array `mem[0:2**DEPTH_LOG2-1]` of `LINE_W` bits. It is not cleared by reset; the bench loads it with `$readmemh`/`$readmemb`. Index = `mem_addr[DEPTH_LOG2-1:0]`; upper address bits are ignored, so addresses wrap and alias.
- Request: port p is requesting when `mem_read[p]|mem_write[p]`. If both are set, the access is a write and `protocol_err` sets.
- FSM states:
  - IDLE → BUSY when any port requests. The grant goes to the first requesting port at or after `rr_ptr`, searching upward with wrap. The FSM latches port, op, index and wdata; later changes on inputs are ignored.
  - BUSY: counter loads `LATENCY-1` and decrements each cycle. At 0, `mem_ready[port]` pulses for 1 cycle. A read loads `mem_rdata[port]` from the array in the same cycle. A write updates the array at the end of that cycle. BUSY → TURN.
  - TURN: 1 cycle with no arbitration, so a requester can drop its request after ready. `rr_ptr` ← granted port+1 (mod `NUM_PORTS`). TURN → IDLE.
- The read and write paths through the array are never active in the same cycle; the array stays single-ported.
- Ports not granted see `mem_ready`=0, and their `mem_rdata` is unchanged.

## Timing
- Reset values: `mem_ready`=0, every `mem_rdata` lane=0, `busy`=0, `grant_id`=0, `protocol_err`=0, FSM=IDLE, `rr_ptr`=0, counter=0.
- Request first seen in IDLE at edge t: `busy`=1 and `grant_id` valid from t+1. `mem_ready` is high during cycle t+LATENCY. TURN occupies t+LATENCY+1, and IDLE can grant again at t+LATENCY+2.
- Throughput: one access per `LATENCY`+2 cycles, shared across all ports.
- Simultaneous requests: exactly one grant. Each other requester is served within `NUM_PORTS`-1 further accesses, so no port starves.
- Read after write to the same index: a read granted after the write's ready returns the new data.
- Reset asserted mid-access: the access is aborted, no array write occurs, no `mem_ready` pulses, and all outputs return to their reset values on the next edge.
- `protocol_err` clears only on `rst`.

## Test plan
- Single read, `LATENCY`=4: `mem[5]`=0xA5A5…; port 0 reads line 5 at t → `mem_ready[0]`=1 only at t+4, `mem_rdata` lane 0=0xA5A5…, port 1 lane stays 0.
- Write then read: port 1 writes 0x1234…_5678 to line 9; after ready, port 0 reads line 9 → returns 0x1234…_5678.
- Contention: ports 0 and 1 request in the same cycle from reset → port 0 served first; port 1's ready comes `LATENCY`+2 cycles later. Repeat with both requesting continuously → grants alternate 0,1,0,1.
- Aliasing, `DEPTH_LOG2`=10: write to address 0x400, read address 0x000 → same data.
- Reset at BUSY cycle 2 of a write to line 3 holding 0xFF…: `mem[3]` still 0xFF…, no ready pulse, `busy`=0 one edge later.
- Port 0 asserts read and write together with addr 7 → treated as a write to line 7, and `protocol_err` stays 1 until `rst`.
